// File: rtl/bram_sp_rw_if.sv
// Port bundle for the single-port-pair block RAM: clear control, byte-strobed
// write port, read request/response and the sticky error flag.
interface bram_sp_rw_if #(
    parameter int DW = 32,
    parameter int AW = 12
);
    localparam int NB = DW / 8;

    logic          CLR;
    logic          BUSY;
    logic [NB-1:0] WE;
    logic [AW-1:0] WA;
    logic [DW-1:0] Di;
    logic          RE;
    logic [AW-1:0] RA;
    logic [DW-1:0] Do;
    logic          DoV;
    logic          ERR;

    modport master (
        output CLR, WE, WA, Di, RE, RA,
        input  BUSY, Do, DoV, ERR
    );

    modport slave (
        input  CLR, WE, WA, Di, RE, RA,
        output BUSY, Do, DoV, ERR
    );
endinterface

// File: rtl/bram_sp_rw.sv
// Simple-dual-port block RAM with byte-lane writes, a 1- or 2-cycle pipelined
// read port, a clear sweep engine and a sticky out-of-range flag.
module bram_sp_rw #(
    parameter int              DW          = 32,
    parameter int              DEPTH       = 11,
    parameter int              AW          = 12,
    parameter int              RD_LAT      = 1,
    parameter int              WRITE_FIRST = 0,
    parameter logic [DW-1:0]   INIT_VAL    = '0
) (
    input  logic        CLK,
    input  logic        RST,
    bram_sp_rw_if.slave s
);
    localparam int NB = DW / 8;
    localparam int LB = (NB > 1) ? $clog2(NB) : 0;
    localparam int IW = AW - LB;
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [MW-1:0] LAST_CNT = MW'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t        state_q, state_d;
    logic [MW-1:0] cnt_q, cnt_d;
    logic          busy;
    logic          err_q;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] do_q;
    logic          dov_q;

    function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_w,
                                                 input logic [NB-1:0] we,
                                                 input logic [DW-1:0] di);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++)
            if (we[i]) r[8*i +: 8] = di[8*i +: 8];
        return r;
    endfunction

    // p0: request decode on the incoming ports
    logic [IW-1:0] widx_p0, ridx_p0;
    logic          w_oor_p0, r_oor_p0;
    logic          wr_acc_p0, rd_acc_p0, coll_p0;
    logic [NB-1:0] weff_p0;

    assign widx_p0   = s.WA[AW-1:LB];
    assign ridx_p0   = s.RA[AW-1:LB];
    assign w_oor_p0  = widx_p0 > LAST_IDX;
    assign r_oor_p0  = ridx_p0 > LAST_IDX;
    assign wr_acc_p0 = !busy && (|s.WE) && !w_oor_p0;
    assign rd_acc_p0 = !busy && s.RE;
    assign coll_p0   = wr_acc_p0 && rd_acc_p0 && (widx_p0 == ridx_p0);
    // Only a write-first collision lets the incoming lanes reach the read data
    assign weff_p0   = (WRITE_FIRST != 0 && coll_p0) ? s.WE : '0;

    generate
        if (LB > 0) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^{s.WA[LB-1:0], s.RA[LB-1:0]};
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (s.CLR) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    assign busy = (state_q == ST_CLEAR);

    // Storage carries no reset so it maps onto block RAM; the sweep clears it
    always_ff @(posedge CLK) begin
        if (busy) begin
            mem[cnt_q] <= INIT_VAL;
        end else if (wr_acc_p0) begin
            for (int i = 0; i < NB; i++)
                if (s.WE[i]) mem[widx_p0[MW-1:0]][8*i +: 8] <= s.Di[8*i +: 8];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            err_q <= 1'b0;
        else if (!busy && s.CLR)
            err_q <= 1'b0;
        else if (!busy && (((|s.WE) && w_oor_p0) || (s.RE && r_oor_p0)))
            err_q <= 1'b1;
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            // p0 -> output: asynchronous array read registered straight into Do
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    dov_q <= 1'b0;
                    do_q  <= '0;
                end else begin
                    dov_q <= rd_acc_p0;
                    if (rd_acc_p0)
                        do_q <= r_oor_p0 ? '0
                              : lane_merge(mem[ridx_p0[MW-1:0]], weff_p0, s.Di);
                end
            end
        end else begin : g_lat2
            logic [DW-1:0] rdat_p1, di_p1;
            logic [NB-1:0] weff_p1;
            logic          oor_p1, vld_p1;

            // p1: registered array read plus the collision context
            always_ff @(posedge CLK) begin
                if (rd_acc_p0) begin
                    rdat_p1 <= mem[ridx_p0[MW-1:0]];
                    di_p1   <= s.Di;
                    weff_p1 <= weff_p0;
                    oor_p1  <= r_oor_p0;
                end
            end

            // p2: merge/zero and present on Do
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    vld_p1 <= 1'b0;
                    dov_q  <= 1'b0;
                    do_q   <= '0;
                end else begin
                    vld_p1 <= rd_acc_p0;
                    dov_q  <= vld_p1;
                    if (vld_p1)
                        do_q <= oor_p1 ? '0 : lane_merge(rdat_p1, weff_p1, di_p1);
                end
            end
        end
    endgenerate

    assign s.BUSY = busy;
    assign s.ERR  = err_q;
    assign s.Do   = do_q;
    assign s.DoV  = dov_q;
endmodule

// File: tb/tb_bram_sp_rw.sv
// Directed bench driving two RAM builds in lockstep: read-first with 1-cycle
// latency, and write-first with 2-cycle latency and a non-zero clear value.
module tb_bram_sp_rw;
    localparam logic [31:0] INIT_A = 32'h0000_0000;
    localparam logic [31:0] INIT_B = 32'h5A5A_A5A5;

    logic CLK;
    logic RST;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n;

    bram_sp_rw_if #(.DW(32), .AW(12)) ifa ();
    bram_sp_rw_if #(.DW(32), .AW(12)) ifb ();

    bram_sp_rw #(.DW(32), .DEPTH(11), .AW(12), .RD_LAT(1), .WRITE_FIRST(0),
                 .INIT_VAL(INIT_A)) dut_a (.CLK(CLK), .RST(RST), .s(ifa.slave));
    bram_sp_rw #(.DW(32), .DEPTH(11), .AW(12), .RD_LAT(2), .WRITE_FIRST(1),
                 .INIT_VAL(INIT_B)) dut_b (.CLK(CLK), .RST(RST), .s(ifb.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic clr, input logic [3:0] we, input logic [11:0] wa,
                         input logic [31:0] di, input logic re, input logic [11:0] ra);
        ifa.CLR = clr; ifa.WE = we; ifa.WA = wa; ifa.Di = di; ifa.RE = re; ifa.RA = ra;
        ifb.CLR = clr; ifb.WE = we; ifb.WA = wa; ifb.Di = di; ifb.RE = re; ifb.RA = ra;
    endtask

    task automatic idle_in();
        drive(1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 12'h000);
    endtask

    task automatic wr(input logic [11:0] wa, input logic [31:0] di, input logic [3:0] we);
        drive(1'b0, we, wa, di, 1'b0, 12'h000);
        @(negedge CLK);
        idle_in();
    endtask

    // Read (optionally with a write on the same edge); a answers one cycle
    // after the request, b one cycle later still.
    task automatic access(input string tag, input logic [3:0] we, input logic [11:0] wa,
                          input logic [31:0] di, input logic [11:0] ra,
                          input logic [31:0] ea, input logic [31:0] eb);
        drive(1'b0, we, wa, di, 1'b1, ra);
        @(negedge CLK);
        idle_in();
        check({tag, ".a.vld"}, 32'(ifa.DoV), 32'd1);
        check({tag, ".a.do"}, ifa.Do, ea);
        check({tag, ".b.vld_early"}, 32'(ifb.DoV), 32'd0);
        @(negedge CLK);
        check({tag, ".a.vld_end"}, 32'(ifa.DoV), 32'd0);
        check({tag, ".a.hold"}, ifa.Do, ea);
        check({tag, ".b.vld"}, 32'(ifb.DoV), 32'd1);
        check({tag, ".b.do"}, ifb.Do, eb);
    endtask

    task automatic rd(input string tag, input logic [11:0] ra,
                      input logic [31:0] ea, input logic [31:0] eb);
        access(tag, 4'h0, 12'h000, 32'h0, ra, ea, eb);
    endtask

    // Counts cycles with BUSY high (bounded); no read response or error may
    // appear meanwhile, whatever the ports carry.
    task automatic count_busy(input string tag, output int cnt);
        cnt = 0;
        while (ifa.BUSY && cnt < 100) begin
            @(negedge CLK);
            cnt++;
            check({tag, ".a.dov_busy"}, 32'(ifa.DoV), 32'd0);
            check({tag, ".b.dov_busy"}, 32'(ifb.DoV), 32'd0);
            check({tag, ".a.err_busy"}, 32'(ifa.ERR), 32'd0);
            check({tag, ".b.err_busy"}, 32'(ifb.ERR), 32'd0);
        end
        check({tag, ".b.busy_done"}, 32'(ifb.BUSY), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        idle_in();
        repeat (2) @(negedge CLK);
        check("rst.a.busy", 32'(ifa.BUSY), 32'd1);
        check("rst.b.busy", 32'(ifb.BUSY), 32'd1);
        check("rst.a.do", ifa.Do, 32'h0);
        check("rst.b.do", ifb.Do, 32'h0);
        check("rst.a.dov", 32'(ifa.DoV), 32'd0);
        check("rst.b.dov", 32'(ifb.DoV), 32'd0);
        check("rst.a.err", 32'(ifa.ERR), 32'd0);
        check("rst.b.err", 32'(ifb.ERR), 32'd0);

        RST = 1'b0;
        count_busy("init", n);
        check("init.busy_cycles", 32'(n), 32'd11);
        for (int i = 0; i < 11; i++)
            rd($sformatf("init.w%0d", i), 12'(i * 4), INIT_A, INIT_B);

        // Byte lanes: only strobed lanes change; misaligned address hits same word
        wr(12'h028, 32'h1122_3344, 4'b1111);
        wr(12'h028, 32'hAABB_CCDD, 4'b0101);
        rd("strb", 12'h028, 32'h11BB_33DD, 32'h11BB_33DD);
        rd("strb.misal", 12'h02B, 32'h11BB_33DD, 32'h11BB_33DD);

        // Same-word collision: a returns old data, b the merged word
        wr(12'h00C, 32'h0000_FFFF, 4'b1111);
        access("coll", 4'b1100, 12'h00C, 32'h1234_0000, 12'h00C, 32'h0000_FFFF, 32'h1234_FFFF);
        rd("coll.after", 12'h00C, 32'h1234_FFFF, 32'h1234_FFFF);
        // Independent ports: write word 5 while reading word 3
        access("indep", 4'b1111, 12'h014, 32'hCAFE_F00D, 12'h00C, 32'h1234_FFFF, 32'h1234_FFFF);
        rd("indep.w5", 12'h014, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Pipelined back-to-back reads on words 0..4
        for (int i = 0; i < 5; i++) wr(12'(i * 4), 32'hC0DE_0000 + 32'(i), 4'b1111);
        for (int t = 0; t < 7; t++) begin
            check($sformatf("pipe.a.vld%0d", t), 32'(ifa.DoV), 32'((t >= 1 && t <= 5) ? 1 : 0));
            check($sformatf("pipe.b.vld%0d", t), 32'(ifb.DoV), 32'((t >= 2 && t <= 6) ? 1 : 0));
            if (t >= 1 && t <= 5) check($sformatf("pipe.a.do%0d", t), ifa.Do, 32'hC0DE_0000 + 32'(t - 1));
            if (t >= 2 && t <= 6) check($sformatf("pipe.b.do%0d", t), ifb.Do, 32'hC0DE_0000 + 32'(t - 2));
            if (t < 5) drive(1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 12'(t * 4));
            else idle_in();
            @(negedge CLK);
        end

        // Out of range write/read and the sticky flag
        check("oor.a.err_pre", 32'(ifa.ERR), 32'd0);
        check("oor.b.err_pre", 32'(ifb.ERR), 32'd0);
        wr(12'h02C, 32'hDEAD_BEEF, 4'b1111);
        check("oor.a.err_wr", 32'(ifa.ERR), 32'd1);
        check("oor.b.err_wr", 32'(ifb.ERR), 32'd1);
        rd("oor.w10", 12'h028, 32'h11BB_33DD, 32'h11BB_33DD);
        rd("oor.rd", 12'h030, 32'h0, 32'h0);
        check("oor.a.err_sticky", 32'(ifa.ERR), 32'd1);
        check("oor.b.err_sticky", 32'(ifb.ERR), 32'd1);

        drive(1'b1, 4'h0, 12'h000, 32'h0, 1'b0, 12'h000);
        @(negedge CLK);
        idle_in();
        check("clr.a.err", 32'(ifa.ERR), 32'd0);
        check("clr.b.err", 32'(ifb.ERR), 32'd0);
        check("clr.a.busy", 32'(ifa.BUSY), 32'd1);
        count_busy("clr", n);
        check("clr.busy_cycles", 32'(n), 32'd11);
        for (int i = 0; i < 11; i++)
            rd($sformatf("clr.w%0d", i), 12'(i * 4), INIT_A, INIT_B);
        rd("oor.rd_far", 12'h7FC, 32'h0, 32'h0);
        check("oor.a.err_rd", 32'(ifa.ERR), 32'd1);
        check("oor.b.err_rd", 32'(ifb.ERR), 32'd1);

        // Reset at sweep count 5 restarts a full sweep; ports ignored while busy
        drive(1'b1, 4'h0, 12'h000, 32'h0, 1'b0, 12'h000);
        @(negedge CLK);
        idle_in();
        repeat (5) @(negedge CLK);
        check("mid.a.busy_pre", 32'(ifa.BUSY), 32'd1);
        RST = 1'b1;
        drive(1'b0, 4'b1111, 12'h000, 32'hFFFF_FFFF, 1'b1, 12'h030);
        #1;
        check("mid.a.busy_rst", 32'(ifa.BUSY), 32'd1);
        check("mid.b.busy_rst", 32'(ifb.BUSY), 32'd1);
        check("mid.a.err_rst", 32'(ifa.ERR), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        count_busy("mid", n);
        check("mid.busy_cycles", 32'(n), 32'd11);
        idle_in();
        rd("mid.w0", 12'h000, INIT_A, INIT_B);
        rd("mid.w10", 12'h028, INIT_A, INIT_B);
        check("mid.a.err_end", 32'(ifa.ERR), 32'd0);
        check("mid.b.err_end", 32'(ifb.ERR), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bram_sp_rw.md
Name: bram_sp_rw

Overview:
- Parametrised simple-dual-port block RAM with one write port, one read port and byte-lane write strobes.
- Configurable word width, depth, read latency and read-during-write mode.
- Built-in clear engine initialises every word after reset or on request.
- Out-of-range accesses are flagged by a sticky error bit.
- Drop-in storage for FIR tap and data buffers behind the AXI-Lite/AXI-Stream front ends.

Parameters:
DW, 32, data word width in bits; must be a multiple of 8; NB = DW/8 byte lanes
DEPTH, 11, number of words
AW, 12, byte-address width of both ports
RD_LAT, 1, read latency in cycles; legal values 1 or 2
WRITE_FIRST, 0, same-word collision: 1 returns new merged data, 0 returns old data
INIT_VAL, 0, DW-bit value written to every word by the clear engine

Ports:
CLK  in  1  clock; all state on rising edge
RST  in  1  reset, asynchronous, active-high
CLR  in  1  single-cycle request to re-run the clear sweep
BUSY  out  1  high while the clear sweep runs
WE  in  NB  write byte strobes; bit i writes Di[8i+7:8i]
WA  in  AW  write byte address
Di  in  DW  write data
RE  in  1  read request
RA  in  AW  read byte address
Do  out  DW  read data
DoV  out  1  one-cycle pulse marking Do valid
ERR  out  1  sticky out-of-range flag

Behaviour:
- Word index = address >> log2(NB). Low log2(NB) address bits are ignored; misaligned addresses access the containing word.
- Reset (RST high, asynchronous):
  - Do=0, DoV=0, ERR=0, BUSY=1.
  - Read pipeline flushed.
  - FSM forced to CLEAR with sweep counter = 0.
- FSM states: CLEAR, IDLE.
  - CLEAR: writes INIT_VAL to word[counter] each cycle, counter increments. After writing DEPTH-1, goes to IDLE next edge. The sweep lasts DEPTH cycles, and BUSY deasserts on the same edge.
  - IDLE: CLR=1 sampled → CLEAR, counter=0, BUSY=1 from the next cycle.
  - CLR while in CLEAR is ignored; the sweep does not restart.
  - RST asserted mid-sweep restarts the sweep from word 0.
- While BUSY=1:
  - WE and RE are ignored, with no DoV and no ERR update.
  - Do holds its value.
- Write (IDLE, WE≠0, index<DEPTH): at the edge, only the lanes whose strobes are set are updated; the other lanes are unchanged. WE=0 means no write.
- Read (IDLE, RE=1):
  - Request sampled at edge k. Do updated and DoV=1 after edge k+RD_LAT-1, i.e. visible in the cycle after edge k for RD_LAT=1.
  - DoV deasserts the following cycle unless another read was issued.
  - Back-to-back reads are accepted every cycle; fully pipelined, no stall.
- Do holds the last read data when DoV=0. It is not gated to 0.
- Collision (RE and WE≠0, same in-range index, same edge):
  - WRITE_FIRST=1: Do = old word with the strobed lanes replaced by Di.
  - WRITE_FIRST=0: Do = old word.
  - Memory is always updated.
- Out of range (index ≥ DEPTH):
  - Write: memory untouched, ERR←1.
  - Read: Do=0 with the normal DoV pulse and latency, ERR←1.
- ERR is sticky. It is cleared only by RST or by a CLR accepted in IDLE; the clear happens on that edge.
- Read and write ports are independent. Simultaneous accesses to different words complete in the same cycle.
- Memory is synthesisable (inferred RAM when RD_LAT=2). No X is driven on Do after reset.

Test Plan:
- Reset then idle: release RST → BUSY=1 for exactly DEPTH=11 cycles. Then read words 0..10 with RE → each Do=0x00000000, one DoV pulse each, RD_LAT cycles after its request.
- Byte strobes: write 0x11223344 with WE=1111 to WA=0x028. Then write 0xAABBCCDD with WE=0101 to the same word. Read RA=0x028 → Do=0x11BB33DD.
- Collision: word 3 = 0x0000FFFF. Same edge: WE=1100 with Di=0x12340000 and RE, both at address 0x00C. WRITE_FIRST=0 → Do=0x0000FFFF; WRITE_FIRST=1 → Do=0x1234FFFF. A subsequent read returns 0x1234FFFF in both builds.
- Out of range: write to 0x02C (index 11) → ERR=1, and a re-read of word 10 is unchanged. Read 0x030 → Do=0 with DoV=1. ERR stays 1 until a CLR in IDLE → ERR=0, BUSY=1 for 11 cycles, and all words then read as INIT_VAL.
- Pipeline: RD_LAT=2, RE held for 5 cycles on addresses 0,4,8,12,16 → five consecutive DoV pulses starting 2 cycles after the first request, carrying the data in request order.
- Reset mid-sweep: assert RST at sweep count 5, release it → BUSY=1 for a further full 11 cycles. WE/RE issued while BUSY produce no DoV and no ERR.
